// File: rtl/jt10_bus_pkg.sv
// Shared definitions for the YM2610 host-bus master: FSM encoding and bus constants.
package jt10_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_ADR,
    ST_GAP1,
    ST_DAT,
    ST_GAP2
  } bus_state_t;

  localparam int   BUSY_BIT  = 7;
  localparam logic ADDR_PORT = 1'b0;
  localparam logic DATA_PORT = 1'b1;

endpackage

// File: rtl/jt10_bus_fifo.sv
// Synchronous request FIFO; read data is presented combinationally from the head slot.
module jt10_bus_fifo #(
  parameter int W  = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/jt10_bus_master.sv
// Host-bus initiator for the YM2610 core: buffers (reg, val) writes and replays them
// as busy-poll, address write, data write sequences timed in cen ticks.
//
//   state | meaning
//   IDLE  | bus released, waiting for a queued request
//   POLL  | cs_n low, sampling the busy flag on dout[7]
//   ADR   | address-port write pulse, din = register
//   GAP1  | one-tick release between phases, addr = data port
//   DAT   | data-port write pulse, din = value
//   GAP2  | one-tick release, addr back to address port
module jt10_bus_master
  import jt10_bus_pkg::*;
#(
  parameter int FIFO_AW  = 3,
  parameter int WR_PULSE = 2,
  parameter int BUSY_TO  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_val,
  output logic [7:0] bus_din,
  output logic       bus_addr,
  output logic       bus_cs_n,
  output logic       bus_wr_n,
  input  logic [7:0] bus_dout,
  output logic       idle,
  output logic       busy_err,
  input  logic       err_clr
);

  bus_state_t       state_q, state_d;
  logic [7:0]       tmo_q, tmo_d, tmo_inc;
  logic [3:0]       pulse_q, pulse_d;
  logic [7:0]       val_q, val_d;
  logic [7:0]       din_d;
  logic             addr_d, cs_d, wr_d;
  logic             err_set;
  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic [FIFO_AW:0] fifo_count;
  logic [15:0]      fifo_rd;
  logic             unused_dout;

  assign unused_dout = ^bus_dout[6:0];

  assign req_ready = ~fifo_full;
  assign push      = req_valid & req_ready;
  assign pop       = cen & (state_q == ST_IDLE) & ~fifo_empty;
  assign idle      = (fifo_count == '0) & (state_q == ST_IDLE);
  assign tmo_inc   = tmo_q + 8'd1;

  jt10_bus_fifo #(.W(16), .AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data ({req_reg, req_val}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Bus pins are computed one tick ahead so every pin comes straight from a flop.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    pulse_d = pulse_q;
    val_d   = val_q;
    din_d   = bus_din;
    addr_d  = bus_addr;
    cs_d    = bus_cs_n;
    wr_d    = bus_wr_n;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cs_d = 1'b1;
        wr_d = 1'b1;
        if (!fifo_empty) begin
          state_d = ST_POLL;
          tmo_d   = '0;
          val_d   = fifo_rd[7:0];
          din_d   = fifo_rd[15:8];
          addr_d  = ADDR_PORT;
          cs_d    = 1'b0;
        end
      end
      ST_POLL: begin
        if (!bus_dout[BUSY_BIT] || (tmo_inc == 8'(BUSY_TO))) begin
          err_set = bus_dout[BUSY_BIT];
          state_d = ST_ADR;
          wr_d    = 1'b0;
          pulse_d = 4'(WR_PULSE - 1);
        end else begin
          tmo_d = tmo_inc;
        end
      end
      ST_ADR: begin
        if (pulse_q == '0) begin
          state_d = ST_GAP1;
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = DATA_PORT;
        end else begin
          pulse_d = pulse_q - 4'd1;
        end
      end
      ST_GAP1: begin
        state_d = ST_DAT;
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        din_d   = val_q;
        pulse_d = 4'(WR_PULSE - 1);
      end
      ST_DAT: begin
        if (pulse_q == '0) begin
          state_d = ST_GAP2;
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = ADDR_PORT;
        end else begin
          pulse_d = pulse_q - 4'd1;
        end
      end
      ST_GAP2: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b1;
        wr_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tmo_q    <= '0;
      pulse_q  <= '0;
      val_q    <= '0;
      bus_din  <= '0;
      bus_addr <= ADDR_PORT;
      bus_cs_n <= 1'b1;
      bus_wr_n <= 1'b1;
      busy_err <= 1'b0;
    end else begin
      if (cen) begin
        state_q  <= state_d;
        tmo_q    <= tmo_d;
        pulse_q  <= pulse_d;
        val_q    <= val_d;
        bus_din  <= din_d;
        bus_addr <= addr_d;
        bus_cs_n <= cs_d;
        bus_wr_n <= wr_d;
      end
      // A clear in the same clk as a timeout wins; that timeout is dropped.
      if (err_clr)             busy_err <= 1'b0;
      else if (cen && err_set) busy_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jt10_bus_master.sv
// Scoreboard bench for jt10_bus_master: expected bus writes are queued at request
// acceptance and matched by a monitor that also models the chip busy flag.
module tb_jt10_bus_master;

  localparam int WRP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_reg = '0;
  logic [7:0] req_val = '0;
  logic [7:0] bus_din;
  logic       bus_addr, bus_cs_n, bus_wr_n;
  logic [7:0] bus_dout = '0;
  logic       idle, busy_err;
  logic       err_clr = 1'b0;

  logic       t_req_valid = 1'b0;
  logic       t_req_ready;
  logic [7:0] t_req_reg = '0;
  logic [7:0] t_req_val = '0;
  logic [7:0] t_bus_din;
  logic       t_bus_addr, t_bus_cs_n, t_bus_wr_n;
  logic [7:0] t_bus_dout = 8'h80;
  logic       t_idle, t_busy_err;
  logic       t_err_clr = 1'b0;

  jt10_bus_master #(.FIFO_AW(3), .WR_PULSE(WRP), .BUSY_TO(64)) dut (
    .clk(clk), .rst(rst), .cen(cen), .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_val(req_val), .bus_din(bus_din), .bus_addr(bus_addr),
    .bus_cs_n(bus_cs_n), .bus_wr_n(bus_wr_n), .bus_dout(bus_dout), .idle(idle),
    .busy_err(busy_err), .err_clr(err_clr)
  );

  jt10_bus_master #(.FIFO_AW(3), .WR_PULSE(WRP), .BUSY_TO(4)) dut_to (
    .clk(clk), .rst(rst), .cen(1'b1), .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_reg(t_req_reg), .req_val(t_req_val), .bus_din(t_bus_din), .bus_addr(t_bus_addr),
    .bus_cs_n(t_bus_cs_n), .bus_wr_n(t_bus_wr_n), .bus_dout(t_bus_dout), .idle(t_idle),
    .busy_err(t_busy_err), .err_clr(t_err_clr)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [8:0] exp_q[$];
  int         cen_mode = 0;
  int         busy_plan = 0;
  bit         random_busy = 1'b0;
  logic       last_cen = 1'b1;
  logic       last_rst = 1'b1;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) begin
    last_cen <= cen;
    last_rst <= rst;
  end

  // Monitor, scoreboard and busy-flag / cen generator.
  logic [10:0] prev_bus = 11'h600;
  logic        prev_wr = 1'b1;
  logic        prev_poll = 1'b0;
  int          wr_ticks = 0, poll_edges = 0, plan_used = 0, busy_left = 0, phase = 0;

  always @(negedge clk) begin
    logic [10:0] cur_bus;
    logic [8:0]  e;
    logic        poll, c;
    cur_bus = {bus_cs_n, bus_wr_n, bus_addr, bus_din};
    poll    = !bus_cs_n && bus_wr_n;
    if (!last_rst) begin
      if (!last_cen) check("hold_on_non_cen", int'(cur_bus), int'(prev_bus));
      if (!prev_wr && !bus_wr_n) begin
        check("addr_din_stable_wr_low", int'({bus_addr, bus_din}), int'(prev_bus[8:0]));
        check("cs_low_with_wr", int'(bus_cs_n), 0);
      end
      if (!prev_wr && last_cen) wr_ticks++;
      if (!prev_wr && bus_wr_n) begin
        check("wr_pulse_ticks", wr_ticks, WRP);
        if (exp_q.size() == 0) begin
          check("sb_unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_addr_din", int'(prev_bus[8:0]), int'(e));
        end
      end
      if (prev_poll && !poll) check("poll_ticks", poll_edges, plan_used + 1);
    end
    if (prev_wr && !bus_wr_n) wr_ticks = 0;
    if (poll && !prev_poll) begin
      plan_used  = random_busy ? int'($urandom_range(0, 6)) : busy_plan;
      busy_left  = plan_used;
      poll_edges = 0;
    end
    case (cen_mode)
      0:       c = 1'b1;
      1:       c = (phase == 0);
      2:       c = 1'($urandom_range(0, 1));
      default: c = 1'b0;
    endcase
    phase = (phase == 2) ? 0 : phase + 1;
    cen   = c;
    if (poll && c) begin
      bus_dout = {busy_left != 0, 7'($urandom)};
      if (busy_left > 0) busy_left--;
      poll_edges++;
    end
    prev_bus  = cur_bus;
    prev_wr   = bus_wr_n;
    prev_poll = poll;
  end

  task automatic push_req(input logic [7:0] r, input logic [7:0] v);
    req_reg = r;
    req_val = v;
    req_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (req_ready) begin
        exp_q.push_back({1'b0, r});
        exp_q.push_back({1'b1, v});
        @(negedge clk);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("push_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (idle) return;
      @(negedge clk);
    end
    check("idle_timeout", int'(idle), 1);
  endtask

  // Counts cen ticks and clks from the pop tick (cs_n falls) to the tick that shows idle.
  task automatic measure_txn(input int exp_ticks, input int exp_clks);
    int ticks, clks;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!bus_cs_n) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("txn_start_seen", int'(seen), 1);
    ticks = 1;
    clks  = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      clks++;
      if (last_cen) ticks++;
      if (idle) break;
    end
    check("txn_cen_ticks", ticks, exp_ticks);
    check("txn_clks", clks, exp_clks);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  act;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_cs_n", int'(bus_cs_n), 1);
    check("rst_wr_n", int'(bus_wr_n), 1);
    check("rst_addr", int'(bus_addr), 0);
    check("rst_din", int'(bus_din), 0);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_idle", int'(idle), 1);
    check("rst_busy_err", int'(busy_err), 0);
    check("rst_to_idle", int'(t_idle), 1);

    // Single write, cen always high, then with cen one clk in three.
    cen_mode = 0;
    busy_plan = 0;
    @(negedge clk);
    push_req(8'h28, 8'hF0);
    measure_txn(2 + WRP + 1 + WRP + 1, (2 + WRP + 1 + WRP) * 1);
    cen_mode = 1;
    repeat (3) @(negedge clk);
    push_req(8'h28, 8'hF0);
    measure_txn(2 + WRP + 1 + WRP + 1, (2 + WRP + 1 + WRP) * 3);

    // Busy stall of 10 sampled ticks, well under the timeout.
    cen_mode = 0;
    busy_plan = 10;
    repeat (2) @(negedge clk);
    push_req(8'h30, 8'h71);
    wait_idle(200);
    check("stall_busy_err", int'(busy_err), 0);
    busy_plan = 0;

    // Backpressure: fill with cen held off, then let the FSM drain.
    cen_mode = 3;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) push_req(8'(8'h40 + i), 8'(8'h90 + 3 * i));
    check("bp_full_ready_low", int'(req_ready), 0);
    check("bp_full_not_idle", int'(idle), 0);
    cen_mode = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    check("bp_ready_after_pop", int'(req_ready), 1);
    check("bp_pop_started_bus", int'(bus_cs_n), 0);
    push_req(8'h48, 8'hC7);
    wait_idle(600);
    check("bp_drained", exp_q.size(), 0);

    // Randomized traffic with random cen and random busy durations.
    cen_mode = 2;
    random_busy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push_req(8'($urandom), 8'($urandom));
    end
    wait_idle(4000);
    check("rand_drained", exp_q.size(), 0);
    check("rand_busy_err", int'(busy_err), 0);
    random_busy = 1'b0;

    // Reset during the data phase with more requests still queued.
    cen_mode = 0;
    @(negedge clk);
    push_req(8'h11, 8'h22);
    push_req(8'h33, 8'h44);
    push_req(8'h55, 8'h66);
    for (int i = 0; i < 200; i++) begin
      if (!bus_wr_n && bus_addr) break;
      @(negedge clk);
    end
    check("dat_phase_reached", int'(!bus_wr_n && bus_addr), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("rst_dat_cs_n", int'(bus_cs_n), 1);
    check("rst_dat_wr_n", int'(bus_wr_n), 1);
    check("rst_dat_idle", int'(idle), 1);
    check("rst_dat_ready", int'(req_ready), 1);
    act = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus_cs_n || !idle) act = 1'b1;
    end
    check("rst_dat_no_activity", int'(act), 0);

    // Timeout instance: busy stuck high, BUSY_TO = 4.
    t_bus_dout = 8'h80;
    t_req_reg = 8'h5A;
    t_req_val = 8'hA5;
    t_req_valid = 1'b1;
    @(negedge clk);
    t_req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!t_bus_cs_n) break;
      @(negedge clk);
    end
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!t_bus_wr_n) break;
      n++;
    end
    check("to_poll_ticks", n, 4);
    check("to_busy_err_set", int'(t_busy_err), 1);
    check("to_adr_din", int'(t_bus_din), 8'h5A);
    for (int i = 0; i < 50; i++) begin
      if (t_idle) break;
      @(negedge clk);
    end
    check("to_idle", int'(t_idle), 1);
    check("to_busy_err_sticky", int'(t_busy_err), 1);
    t_err_clr = 1'b1;
    @(negedge clk);
    t_err_clr = 1'b0;
    check("to_err_cleared", int'(t_busy_err), 0);

    // Clear held through a second timeout: clear wins, and requests still flow.
    t_err_clr = 1'b1;
    t_req_valid = 1'b1;
    @(negedge clk);
    t_req_valid = 1'b0;
    act = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!t_bus_wr_n) act = 1'b1;
      if (t_idle) break;
    end
    check("to2_write_done", int'(act), 1);
    check("to2_clear_wins", int'(t_busy_err), 0);
    t_err_clr = 1'b0;

    check("sb_final_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
